// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: FSM state encoding and
// the fill bit used for the divide-by-zero result.
package div_unit_pkg;

   typedef enum logic [1:0] {
      DIV_IDLE    = 2'd0,
      DIV_DIVZERO = 2'd1,
      DIV_ON      = 2'd2,
      DIV_END     = 2'd3
   } div_state_e;

   // Replicated across both result halves on a divide-by-zero.
   localparam logic DIV_ZERO_RESULT = 1'b0;

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division step: shift {rem,quo} left, try rem - b, and keep
// the difference when it does not borrow.
module div_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [2*WIDTH-1:0] remquo,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] remquo_nx
);

   logic [WIDTH:0] partial;
   logic [WIDTH:0] diff;
   logic           take;

   // The shifted remainder is WIDTH+1 bits; when its top bit is set it
   // exceeds any divisor, so the trial always succeeds and the low WIDTH
   // bits of the difference are exact modulo 2^WIDTH.
   always_comb begin
      partial   = remquo[2*WIDTH-1:WIDTH-1];
      diff      = {1'b0, partial[WIDTH-1:0]} - {1'b0, b};
      take      = partial[WIDTH] | ~diff[WIDTH];
      remquo_nx = take ? {diff[WIDTH-1:0], remquo[WIDTH-2:0], 1'b1}
                       : {partial[WIDTH-1:0], remquo[WIDTH-2:0], 1'b0};
   end

endmodule

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per cycle,
// result = {remainder, quotient}, busy stalls the pipeline while working.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               signed_div,
   input  logic               annul,
   input  logic [WIDTH-1:0]   opdata1,
   input  logic [WIDTH-1:0]   opdata2,
   output logic [2*WIDTH-1:0] result,
   output logic               ready,
   output logic               busy
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   div_state_e         state, state_nx;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] remquo, remquo_nx;
   logic [WIDTH-1:0]   b_mag, a_mag_in, b_mag_in, quo_fix, rem_fix;
   logic               neg_q, neg_r;
   logic               accept, last;

   assign accept   = (state == DIV_IDLE) & start & ~annul;
   assign last     = (cnt == CW'(WIDTH - 1));
   assign a_mag_in = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
   assign b_mag_in = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;
   assign quo_fix  = neg_q ? -remquo_nx[WIDTH-1:0] : remquo_nx[WIDTH-1:0];
   assign rem_fix  = neg_r ? -remquo_nx[2*WIDTH-1:WIDTH] : remquo_nx[2*WIDTH-1:WIDTH];

   div_step #(.WIDTH(WIDTH)) u_step (
      .remquo   (remquo),
      .b        (b_mag),
      .remquo_nx(remquo_nx)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= DIV_IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      ready    = 1'b0;
      busy     = 1'b0;
      case (state)
         DIV_IDLE: begin
            if (accept) begin
               busy     = 1'b1;
               state_nx = (opdata2 == '0) ? DIV_DIVZERO : DIV_ON;
            end
         end
         DIV_DIVZERO: begin
            busy     = 1'b1;
            state_nx = annul ? DIV_IDLE : DIV_END;
         end
         DIV_ON: begin
            busy = 1'b1;
            if (annul)     state_nx = DIV_IDLE;
            else if (last) state_nx = DIV_END;
         end
         DIV_END: begin
            ready = 1'b1;
            if (annul || !start) state_nx = DIV_IDLE;
         end
         default: state_nx = DIV_IDLE;
      endcase
      busy = busy & rst;
   end

   // Annul wins over completion, so result only loads when annul is low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt    <= '0;
         remquo <= '0;
         b_mag  <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         result <= '0;
      end else if (accept) begin
         cnt    <= '0;
         remquo <= {{WIDTH{1'b0}}, a_mag_in};
         b_mag  <= b_mag_in;
         neg_q  <= signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
         neg_r  <= signed_div & opdata1[WIDTH-1];
      end else if (state == DIV_ON && !annul) begin
         remquo <= remquo_nx;
         cnt    <= cnt + CW'(1);
         if (last) result <= {rem_fix, quo_fix};
      end else if (state == DIV_DIVZERO && !annul) begin
         result <= {(2*WIDTH){DIV_ZERO_RESULT}};
      end
   end

endmodule
